// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_port_arbiter
// Description : Shares the single data-memory port between the CPU memory
//               stage and the external word loader. Stores complete in the
//               grant cycle, loads return one cycle later (RD_WAIT). The
//               loader normally yields to the CPU, but a starvation counter
//               forces a loader grant once it has waited STARVE_MAX cycles.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   sys_clk, sys_arstn          clock (rising edge), async active-low reset
//   cpu_req/we/ctrl/addr/wdata  CPU access request, held until cpu_ack
//   cpu_ack, cpu_rdata          completion pulse, load data (held after)
//   cpu_stall                   cpu_req & ~cpu_ack
//   ldr_valid/addr/data         loader word write request
//   ldr_ready                   loader handshake (transfer on valid&ready)
//   mem_en/we/ctrl/addr/wdata   data-memory port outputs
//   mem_rdata                   memory read data, one cycle after read strobe
//   busy                        a load is waiting for its data
//   conflict_cnt                saturating count of IDLE cycles with both
//                               requesters pending
// ============================================================================
module dmem_port_arbiter #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                LDR_AW     = 5,
  parameter int                CTRL_W     = 8,
  parameter logic [CTRL_W-1:0] LDR_CTRL   = 'h0C,
  parameter int                STARVE_MAX = 4,
  parameter int                CNT_W      = 16
) (
  input  logic              sys_clk,
  input  logic              sys_arstn,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [CTRL_W-1:0] cpu_ctrl,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ldr_valid,
  input  logic [LDR_AW-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_data,
  output logic              ldr_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [CTRL_W-1:0] mem_ctrl,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [CNT_W-1:0]  conflict_cnt
);

  // Starvation counter only needs to reach STARVE_MAX; keep at least 1 bit.
  localparam int               SC_W         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0]  c_starve_max = SC_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] c_cnt_max    = '1;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_rdata_q;
  logic [SC_W-1:0]   r_starve_cnt;
  logic [CNT_W-1:0]  r_conflict_cnt;
  logic              w_ldr_grant;

  // --------------------------------------------------------------------------
  // Next state and port steering. Everything is qualified by sys_arstn so all
  // outputs read zero while reset is held, even with requests asserted.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_ldr_grant = 1'b0;
    cpu_ack     = 1'b0;
    cpu_rdata   = r_rdata_q;
    ldr_ready   = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_ctrl    = '0;
    mem_addr    = '0;
    mem_wdata   = '0;

    if (sys_arstn) begin
      case (r_state)
        IDLE: begin
          w_ldr_grant = ldr_valid & (~cpu_req | (r_starve_cnt >= c_starve_max));
          if (w_ldr_grant) begin
            ldr_ready = 1'b1;
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_ctrl  = LDR_CTRL;
            mem_addr  = ADDR_W'({ldr_addr, 2'b00});
            mem_wdata = ldr_data;
          end else if (cpu_req) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_ctrl  = cpu_ctrl;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            // Stores retire in the grant cycle; loads wait for the data.
            if (cpu_we) begin
              cpu_ack = 1'b1;
            end else begin
              w_state_nxt = RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          cpu_ack     = 1'b1;
          cpu_rdata   = mem_rdata;
          w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign cpu_stall    = sys_arstn & cpu_req & ~cpu_ack;
  assign busy         = (r_state != IDLE);
  assign conflict_cnt = r_conflict_cnt;

  // --------------------------------------------------------------------------
  // State, captured load data, starvation and conflict counters.
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_arstn) begin
    if (!sys_arstn) begin
      r_state        <= IDLE;
      r_rdata_q      <= '0;
      r_starve_cnt   <= '0;
      r_conflict_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (r_state == RD_WAIT) begin
        r_rdata_q <= mem_rdata;
      end

      if (ldr_valid && ldr_ready) begin
        r_starve_cnt <= '0;
      end else if (ldr_valid && (r_starve_cnt < c_starve_max)) begin
        r_starve_cnt <= r_starve_cnt + SC_W'(1);
      end

      if ((r_state == IDLE) && cpu_req && ldr_valid && (r_conflict_cnt != c_cnt_max)) begin
        r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_port_arbiter
// Description : Self-checking bench for dmem_port_arbiter. Directed steps
//               cover store, load, loader, starvation, reset and the
//               STARVE_MAX=0 variant; a randomized phase is compared each
//               cycle against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_port_arbiter;

  localparam int SM = 4;

  logic        sys_clk;
  logic        sys_arstn;
  logic        cpu_req;
  logic        cpu_we;
  logic [7:0]  cpu_ctrl;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        ldr_valid;
  logic [4:0]  ldr_addr;
  logic [31:0] ldr_data;
  logic [31:0] mem_rdata;

  logic        cpu_ack, cpu_stall, ldr_ready, mem_en, mem_we, busy;
  logic [31:0] cpu_rdata, mem_addr, mem_wdata;
  logic [7:0]  mem_ctrl;
  logic [15:0] conflict_cnt;

  logic        z_cpu_ack, z_cpu_stall, z_ldr_ready, z_mem_en, z_mem_we, z_busy;
  logic [31:0] z_cpu_rdata, z_mem_addr, z_mem_wdata;
  logic [7:0]  z_mem_ctrl;
  logic [15:0] z_conflict_cnt;

  dmem_port_arbiter #(.STARVE_MAX(SM)) u_dut (
    .sys_clk(sys_clk), .sys_arstn(sys_arstn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_ctrl(cpu_ctrl), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ldr_valid(ldr_valid), .ldr_addr(ldr_addr), .ldr_data(ldr_data), .ldr_ready(ldr_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_ctrl(mem_ctrl), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .conflict_cnt(conflict_cnt)
  );

  dmem_port_arbiter #(.STARVE_MAX(0)) u_dut0 (
    .sys_clk(sys_clk), .sys_arstn(sys_arstn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_ctrl(cpu_ctrl), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(z_cpu_ack), .cpu_rdata(z_cpu_rdata), .cpu_stall(z_cpu_stall),
    .ldr_valid(ldr_valid), .ldr_addr(ldr_addr), .ldr_data(ldr_data), .ldr_ready(z_ldr_ready),
    .mem_en(z_mem_en), .mem_we(z_mem_we), .mem_ctrl(z_mem_ctrl), .mem_addr(z_mem_addr),
    .mem_wdata(z_mem_wdata), .mem_rdata(mem_rdata), .busy(z_busy), .conflict_cnt(z_conflict_cnt)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model: "a load is outstanding", loader wait count, conflict
  // count and the last returned load word.
  bit          m_rd      = 1'b0;
  int          m_starve  = 0;
  int          m_conf    = 0;
  logic [31:0] m_rdq     = 32'h0;
  bit          m_last_ack   = 1'b0;
  bit          m_last_ready = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rd = 1'b0; m_starve = 0; m_conf = 0; m_rdq = 32'h0;
    m_last_ack = 1'b0; m_last_ready = 1'b0;
  endtask

  // Called at posedge+1 with inputs applied; samples at the falling edge,
  // compares every output with the model, then advances the model.
  task automatic eval();
    logic        e_ack, e_stall, e_ready, e_en, e_we, e_busy;
    logic [7:0]  e_ctrl;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [15:0] e_conf;
    bit          ldr_win;
    #4;
    e_ack = 0; e_stall = 0; e_ready = 0; e_en = 0; e_we = 0; e_busy = 0;
    e_ctrl = 8'h0; e_addr = 32'h0; e_wdata = 32'h0; e_rdata = m_rdq;
    e_conf = 16'(m_conf); ldr_win = 1'b0;
    if (sys_arstn) begin
      if (m_rd) begin
        e_busy = 1; e_ack = 1; e_rdata = mem_rdata;
      end else begin
        ldr_win = ldr_valid && (!cpu_req || m_starve >= SM);
        if (ldr_win) begin
          e_ready = 1; e_en = 1; e_we = 1; e_ctrl = 8'h0C;
          e_addr = 32'(ldr_addr) * 4; e_wdata = ldr_data;
        end else if (cpu_req) begin
          e_en = 1; e_we = cpu_we; e_ctrl = cpu_ctrl;
          e_addr = cpu_addr; e_wdata = cpu_wdata; e_ack = cpu_we;
        end
      end
      e_stall = cpu_req && !e_ack;
    end
    chk("cpu_ack",      32'(cpu_ack),      32'(e_ack));
    chk("cpu_stall",    32'(cpu_stall),    32'(e_stall));
    chk("cpu_rdata",    cpu_rdata,         e_rdata);
    chk("ldr_ready",    32'(ldr_ready),    32'(e_ready));
    chk("mem_en",       32'(mem_en),       32'(e_en));
    chk("mem_we",       32'(mem_we),       32'(e_we));
    chk("mem_ctrl",     32'(mem_ctrl),     32'(e_ctrl));
    chk("mem_addr",     mem_addr,          e_addr);
    chk("mem_wdata",    mem_wdata,         e_wdata);
    chk("busy",         32'(busy),         32'(e_busy));
    chk("conflict_cnt", 32'(conflict_cnt), 32'(e_conf));
    m_last_ack = e_ack; m_last_ready = e_ready;
    if (!sys_arstn) begin
      model_reset();
    end else begin
      if (e_ready) m_starve = 0;
      else if (ldr_valid) m_starve = (m_starve + 1 > SM) ? SM : m_starve + 1;
      if (!m_rd && cpu_req && ldr_valid && m_conf < 65535) m_conf++;
      if (m_rd) begin
        m_rdq = mem_rdata; m_rd = 1'b0;
      end else if (!ldr_win && cpu_req && !cpu_we) begin
        m_rd = 1'b1;
      end
    end
  endtask

  task automatic adv();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic cpu_set(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
    cpu_req = req; cpu_we = we; cpu_ctrl = 8'h02; cpu_addr = addr; cpu_wdata = wdata;
  endtask

  task automatic ldr_set(input logic v, input logic [4:0] a, input logic [31:0] d);
    ldr_valid = v; ldr_addr = a; ldr_data = d;
  endtask

  initial begin
    sys_arstn = 1'b0;
    cpu_set(1'b1, 1'b1, 32'h44, 32'h5);
    ldr_set(1'b1, 5'd1, 32'h6);
    mem_rdata = 32'h0;
    model_reset();
    adv();
    // Reset held with both requesters active: every output must read zero.
    eval(); adv();
    eval(); adv();
    sys_arstn = 1'b1;
    cpu_set(1'b0, 1'b0, 32'h0, 32'h0);
    ldr_set(1'b0, 5'd0, 32'h0);
    eval(); adv();

    // CPU store: completes in the grant cycle.
    cpu_set(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    eval();
    chk("t2_store_ack", 32'(cpu_ack), 32'd1);
    chk("t2_store_we",  32'(mem_we),  32'd1);
    adv();

    // CPU load: ack one cycle later with memory data, held afterwards.
    cpu_set(1'b1, 1'b0, 32'h10, 32'h0);
    eval();
    chk("t3_load_ack_c1", 32'(cpu_ack), 32'd0);
    adv();
    mem_rdata = 32'hDEADBEEF;
    eval();
    chk("t3_load_ack_c2", 32'(cpu_ack), 32'd1);
    chk("t3_load_data",   cpu_rdata,    32'hDEADBEEF);
    adv();
    cpu_set(1'b0, 1'b0, 32'h0, 32'h0);
    mem_rdata = 32'h0;
    eval();
    chk("t3_data_held", cpu_rdata, 32'hDEADBEEF);
    adv();

    // Loader alone: one word per cycle.
    ldr_set(1'b1, 5'd3, 32'h1234);
    eval();
    chk("t4_ldr_addr", mem_addr, 32'h0C);
    adv();
    ldr_set(1'b1, 5'd4, 32'h5678);
    eval();
    chk("t4_ldr_ready2", 32'(ldr_ready), 32'd1);
    adv();
    ldr_set(1'b0, 5'd0, 32'h0);
    eval(); adv();

    // Back-to-back CPU loads against a waiting loader: loader forced in on
    // the third IDLE cycle, once it has waited four cycles.
    cpu_set(1'b1, 1'b0, 32'h20, 32'h0);
    ldr_set(1'b1, 5'd7, 32'hCAFE0007);
    eval(); chk("t5_cpu_first", 32'(ldr_ready), 32'd0); adv();
    mem_rdata = 32'h11111111;
    eval(); adv();
    cpu_set(1'b1, 1'b0, 32'h24, 32'h0);
    eval(); chk("t5_cpu_second", 32'(ldr_ready), 32'd0); adv();
    mem_rdata = 32'h22222222;
    eval(); adv();
    cpu_set(1'b1, 1'b0, 32'h28, 32'h0);
    eval();
    chk("t5_ldr_forced", 32'(ldr_ready), 32'd1);
    chk("t5_cpu_stall",  32'(cpu_stall), 32'd1);
    chk("t5_ldr_addr",   mem_addr,       32'h1C);
    adv();
    ldr_set(1'b0, 5'd0, 32'h0);
    eval(); chk("t5_cpu_resume", 32'(mem_en & ~mem_we), 32'd1); adv();
    mem_rdata = 32'h33333333;
    eval(); chk("t5_conflicts", 32'(conflict_cnt), 32'd3); adv();
    cpu_set(1'b0, 1'b0, 32'h0, 32'h0);
    eval(); adv();

    // Randomized traffic; requests held until their handshake completes.
    for (int i = 0; i < 400; i++) begin
      if (!cpu_req || m_last_ack) begin
        cpu_req   = ($urandom_range(0, 99) < 60);
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_ctrl  = 8'($urandom);
        cpu_addr  = $urandom;
        cpu_wdata = $urandom;
      end
      if (!ldr_valid || m_last_ready) begin
        ldr_valid = ($urandom_range(0, 99) < 50);
        ldr_addr  = 5'($urandom);
        ldr_data  = $urandom;
      end
      mem_rdata = $urandom;
      eval(); adv();
    end
    for (int k = 0; k < 4; k++) begin
      if (m_last_ack) cpu_req = 1'b0;
      ldr_valid = 1'b0;
      eval(); adv();
    end

    // Async reset in the middle of RD_WAIT: no ack, outputs clear at once.
    cpu_set(1'b1, 1'b0, 32'h30, 32'h0);
    eval(); adv();
    mem_rdata = 32'hAAAA5555;
    #2;
    chk("t1_pre_busy", 32'(busy), 32'd1);
    sys_arstn = 1'b0;
    #1;
    chk("t1_ack",      32'(cpu_ack),      32'd0);
    chk("t1_busy",     32'(busy),         32'd0);
    chk("t1_conflict", 32'(conflict_cnt), 32'd0);
    chk("t1_rdata",    cpu_rdata,         32'd0);
    model_reset();
    adv();
    eval(); adv();
    cpu_set(1'b0, 1'b0, 32'h0, 32'h0);
    sys_arstn = 1'b1;
    eval(); adv();

    // STARVE_MAX=0 instance: loader wins outright, CPU stalls.
    cpu_set(1'b1, 1'b1, 32'h40, 32'h11);
    ldr_set(1'b1, 5'd2, 32'h22);
    eval();
    chk("t6_ldr_ready", 32'(z_ldr_ready), 32'd1);
    chk("t6_cpu_stall", 32'(z_cpu_stall), 32'd1);
    chk("t6_cpu_ack",   32'(z_cpu_ack),   32'd0);
    chk("t6_mem_addr",  z_mem_addr,       32'h08);
    adv();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
